// File: rtl/pp_align_scheduler.sv
// Collects N_PP exponent/digit-product pairs while tracking the group maximum exponent.
// It then steps them through the shared alignment unit and accumulates a signed group sum.
module pp_align_scheduler #(
  parameter int N_PP  = 8,
  parameter int ACC_W = 19
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              in_exp,
  input  logic [4:0]              in_pp,
  output logic [4:0]              align_exp,
  output logic [4:0]              align_exp_max,
  output logic [4:0]              align_pp,
  input  logic [15:0]             align_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic [4:0]              out_exp_max,
  output logic                    busy
);

  localparam int CW = (N_PP > 1) ? $clog2(N_PP) : 1;

  typedef enum logic [1:0] {LOAD, ALIGN, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic [4:0]              exp_max;
  logic [4:0]              exp_buf [N_PP];
  logic [4:0]              pp_buf  [N_PP];
  logic                    load_fire;
  logic                    last_in;
  logic                    last_align;

  // 16'h8000 is the unit's negative zero; it must not count as -32768.
  function automatic logic signed [ACC_W-1:0] align_term(input logic [15:0] r);
    if (r == 16'h8000) return '0;
    return ACC_W'($signed(r));
  endfunction

  assign in_ready      = (state == LOAD);
  assign load_fire     = in_valid && in_ready;
  assign last_in       = (cnt == CW'(N_PP - 1));
  assign last_align    = (idx == CW'(N_PP - 1));
  assign acc_next      = acc + align_term(align_result);
  assign align_exp     = (state == ALIGN) ? exp_buf[idx] : 5'd0;
  assign align_pp      = (state == ALIGN) ? pp_buf[idx]  : 5'd0;
  assign align_exp_max = (state == ALIGN) ? exp_max      : 5'd0;

  // Group buffer: data only, contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      exp_buf[cnt] <= in_exp;
      pp_buf[cnt]  <= in_pp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      cnt         <= '0;
      idx         <= '0;
      acc         <= '0;
      exp_max     <= '0;
      out_valid   <= 1'b0;
      out_sum     <= '0;
      out_exp_max <= '0;
      busy        <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          if (load_fire) begin
            if (cnt == '0 || in_exp > exp_max) exp_max <= in_exp;
            if (last_in) begin
              state <= ALIGN;
              cnt   <= '0;
              idx   <= '0;
              acc   <= '0;
              busy  <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ALIGN: begin
          acc <= acc_next;
          idx <= idx + CW'(1);
          if (last_align) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            out_sum     <= acc_next;
            out_exp_max <= exp_max;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= LOAD;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: doc/pp_align_scheduler.md
Name: pp_align_scheduler

Overview:
- Sequences the shared combinational alignment unit in the SD4 MAC. That unit takes exp, exp_max and signed_pp and returns aligned_pp.
- Collects a group of N_PP partial products, each a 5-bit exponent plus a 5-bit sign-magnitude digit product, and tracks their maximum exponent.
- Then feeds the buffered entries through the alignment unit one per cycle and accumulates the aligned results into a signed sum.
- Sits between the partial-product generator (valid/ready input) and the normaliser (valid/ready output).

Parameters:
- N_PP, 8: partial products per group; must be ≥ 2.
- ACC_W, 19: accumulator width; must be ≥ 16 + clog2(N_PP).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  partial product presented.
- in_ready  output  1  scheduler accepts a partial product this cycle.
- in_exp  input  5  exponent of the partial product.
- in_pp  input  5  sign-magnitude partial product; bit 4 is the sign.
- align_exp  output  5  exponent driven to the alignment unit.
- align_exp_max  output  5  group maximum exponent driven to the alignment unit.
- align_pp  output  5  partial product driven to the alignment unit.
- align_result  input  16  aligned_pp returned by the alignment unit, same cycle.
- out_valid  output  1  group sum available.
- out_ready  input  1  downstream accepts the sum.
- out_sum  output  ACC_W  signed two's-complement group sum.
- out_exp_max  output  5  group maximum exponent.
- busy  output  1  high in ALIGN or DONE.

Behaviour:
- Reset values: FSM=LOAD; cnt, idx, acc and exp_max = 0. Registered outputs: out_valid=0, out_sum=0, out_exp_max=0, busy=0.
- Reset values, combinational outputs: in_ready=1 (first cycle after reset); align_exp, align_exp_max and align_pp = 0.
- FSM states: LOAD, ALIGN, DONE.
- LOAD, handshake and exponent tracking:
  - in_ready=1; a transfer occurs when in_valid && in_ready.
  - Each transfer writes {in_exp, in_pp} to buffer[cnt] and increments cnt.
  - exp_max is loaded with in_exp on the first transfer (cnt==0). Afterwards exp_max = max(exp_max, in_exp), unsigned; ties leave it unchanged.
  - in_valid gaps do not advance cnt.
- LOAD exit: on the N_PP-th transfer, the next state is ALIGN with idx=0, acc=0 and cnt=0. The exp_max register already includes that final exponent.
- ALIGN outputs: align_exp=buffer[idx].exp, align_exp_max=exp_max, align_pp=buffer[idx].pp. Outputs are 0 in all other states.
- ALIGN accumulation:
  - Each cycle: acc <= acc + sext(v), where v is align_result interpreted as 16-bit two's complement.
  - Exception: align_result == 16'h8000 (negative zero, from a zero magnitude or everything shifted out) is treated as 0.
  - idx increments each cycle.
- ALIGN exit: after exactly N_PP cycles (idx==N_PP-1 accumulating), go to DONE. out_sum = final acc and out_exp_max = exp_max, both registered on entry.
- ALIGN has no stall; in_ready=0 throughout.
- DONE: out_valid=1 and out_sum/out_exp_max held stable until out_ready. On out_valid && out_ready the next state is LOAD with out_valid=0; in_ready=1 on the following cycle.
- Latency: the last input transfer at cycle T gives ALIGN in T+1..T+N_PP and out_valid=1 at T+N_PP+1.
- Exponent differences above 15 are legal; the alignment unit yields 0 or 8000h, and 8000h is handled as above.
- Overflow is impossible when ACC_W meets the minimum; no saturation logic.
- rst asserted in any state, including mid-ALIGN or in DONE with out_valid=1:
  - next cycle is LOAD with all reset values;
  - the partial group is discarded;
  - no out_valid pulse is produced.
- Buffer contents need not be cleared by reset.

Test Plan:
All scenarios use N_PP=4, ACC_W=18 and the team's alignment unit connected.
1. Equal exponents: four transfers of exp=5, pp=5'b00011 -> out_sum=24576 (4×6144), out_exp_max=5, out_valid 5 cycles after the last transfer.
2. Mixed exponents: exps 10, 8, 10, 3, all pp=5'b00001 -> align_exp_max=10 on every ALIGN cycle, out_sum=2048+512+2048+16=4624.
3. Signs and negative zero: pp 5'b10011, 5'b00011, 5'b10000, 5'b00001 at exp=7 -> third align_result=8000h treated as 0, out_sum=2048.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_sum and out_exp_max stable, in_ready=0; after the handshake in_ready=1 the next cycle.
5. Input gaps: insert in_valid=0 cycles between transfers -> cnt holds, result identical to scenario 2.
6. Reset mid-ALIGN: assert rst for 1 cycle at idx=2 -> next cycle LOAD, in_ready=1, out_valid=0, align_* outputs 0. A following clean group of scenario 1 gives 24576.
